// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: divider state encoding and add/sub mode selects
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/seq_divider_add_sub_unit.sv
// add_sub_unit: N-bit ripple adder/subtractor; carIn=1 subtracts (inp1 - inp2)
module add_sub_unit #(
  parameter int N = 65
) (
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  input  logic         carIn,
  output logic [N-1:0] ans,
  output logic         carOut,
  output logic         overflow
);
  logic [N:0]   c;
  logic [N-1:0] b;
  assign c[0] = carIn;
  assign b = inp2 ^ {N{carIn}};
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign ans[i]   = inp1[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (inp1[i] & b[i]) | (c[i] & (inp1[i] ^ b[i]));
  end
  assign carOut   = c[N];
  assign overflow = c[N] ^ c[N-1];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         divByZero
);
  localparam int CW = $clog2(N + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_reg, r_reg, dsr, q_nxt, r_nxt;
  logic [N:0]    p, t;
  logic          no_borrow, ovf, unused_ok;
  assign p = {r_reg, q_reg[N-1]};
  add_sub_unit #(.N(N + 1)) u_add_sub (
    .inp1(p), .inp2({1'b0, dsr}), .carIn(SUB),
    .ans(t), .carOut(no_borrow), .overflow(ovf)
  );
  // p < 2*divisor always holds, so t never needs its top bit
  assign unused_ok = ^{ovf, t[N]};
  assign r_nxt = no_borrow ? t[N-1:0] : p[N-1:0];
  assign q_nxt = {q_reg[N-2:0], no_borrow};
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      cnt       <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dsr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: begin
          done <= 1'b0;
          if (!start) state <= IDLE;
          else if (divisor == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
            divByZero <= 1'b1;
          end else begin
            state     <= RUN;
            busy      <= 1'b1;
            dsr       <= divisor;
            q_reg     <= dividend;
            r_reg     <= '0;
            cnt       <= CW'(N);
            divByZero <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for N=8 directed cases and N=64 random operands
module tb_seq_divider;
  logic clk = 1'b0, rstN = 1'b0;
  logic s8 = 1'b0, busy8, done8, dz8;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic s64 = 1'b0, busy64, done64, dz64;
  logic [63:0] a64 = '0, b64 = '0, q64, r64;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [7:0] q; logic [7:0] r; logic dz;} exp8_t;
  typedef struct packed {logic [63:0] a; logic [63:0] b; logic [63:0] q; logic [63:0] r;} exp64_t;
  exp8_t  sb8[$];
  exp64_t sb64[$];

  always #5 clk = ~clk;

  seq_divider #(.N(8)) d8 (
    .clk(clk), .rstN(rstN), .start(s8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .divByZero(dz8)
  );
  seq_divider #(.N(64)) d64 (
    .clk(clk), .rstN(rstN), .start(s64), .dividend(a64), .divisor(b64),
    .busy(busy64), .done(done64), .quotient(q64), .remainder(r64), .divByZero(dz64)
  );

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    exp8_t e;
    e.q  = (b == 0) ? 8'hFF : a / b;
    e.r  = (b == 0) ? a : a % b;
    e.dz = (b == 0);
    sb8.push_back(e);
    a8 = a; b8 = b; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  task automatic wait8(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (done8 !== 1'b1 && lat < 200) begin
      if (busy8) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    #12;
    vectors++;
    if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset8: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0", busy8, done8, q8, r8, dz8);
    end
    vectors++;
    if ({busy64, done64, q64, r64, dz64} !== 131'd0) begin
      miscompares++;
      $display("FAIL reset64: got busy=%b done=%b q=%h r=%h dz=%b, want all 0", busy64, done64, q64, r64, dz64);
    end
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, nb;
    exp8_t e;
    issue8(8'd100, 8'd7);
    wait8(lat, nb);
    vectors++;
    if (lat !== 9 || nb !== 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d clocks busy %0d, want 9 clocks busy 8", lat, nb);
    end
    e = sb8.pop_front();
    vectors++;
    if ({q8, r8, dz8} !== {e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b", q8, r8, dz8, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done8, busy8, q8, r8} !== {2'b00, e.q, e.r}) begin
      miscompares++;
      $display("FAIL basic_pulse: got done=%b busy=%b q=%0d r=%0d, want done=0 busy=0 held results", done8, busy8, q8, r8);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    exp8_t e;
    issue8(8'd255, 8'd1);
    wait8(lat, nb);
    e = sb8.pop_front();
    vectors++;
    if ({lat, q8, r8, dz8} !== {32'd9, e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d dz=%b, want lat=9 q=%0d r=%0d", lat, q8, r8, dz8, e.q, e.r);
    end
    issue8(8'd5, 8'd9);
    vectors++;
    if ({done8, busy8} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_nobubble: got done=%b busy=%b, want done=0 busy=1", done8, busy8);
    end
    wait8(lat, nb);
    e = sb8.pop_front();
    vectors++;
    if ({lat, q8, r8, dz8} !== {32'd9, e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dz=%b, want lat=9 q=%0d r=%0d", lat, q8, r8, dz8, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat, nb;
    exp8_t e;
    issue8(8'd37, 8'd0);
    wait8(lat, nb);
    vectors++;
    if (lat !== 1 || nb !== 0) begin
      miscompares++;
      $display("FAIL dz_latency: got %0d clocks busy %0d, want 1 clock busy 0", lat, nb);
    end
    e = sb8.pop_front();
    vectors++;
    if ({q8, r8, dz8} !== {e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%b, want q=%h r=%0d dz=%b", q8, r8, dz8, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done8, busy8, dz8} !== 3'b001) begin
      miscompares++;
      $display("FAIL dz_hold: got done=%b busy=%b dz=%b, want 0 0 1", done8, busy8, dz8);
    end
    issue8(8'd37, 8'd5);
    vectors++;
    if (dz8 !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_clear: got dz=%b, want 0", dz8);
    end
    wait8(lat, nb);
    e = sb8.pop_front();
    vectors++;
    if ({lat, q8, r8, dz8} !== {32'd9, e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL dz_after: got lat=%0d q=%0d r=%0d dz=%b, want lat=9 q=%0d r=%0d dz=0", lat, q8, r8, dz8, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat, nb, ndone;
    exp8_t e;
    issue8(8'd200, 8'd3);
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'd9; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'd1; b8 = 8'd0;
    wait8(lat, nb);
    e = sb8.pop_front();
    vectors++;
    if ({done8, q8, r8, dz8} !== {1'b1, e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL ignore_result: got done=%b q=%0d r=%0d dz=%b, want done=1 q=%0d r=%0d dz=0", done8, q8, r8, dz8, e.q, e.r);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL ignore_single: got %0d extra done/busy cycles, want 0", ndone);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nb, ndone;
    exp8_t e;
    issue8(8'd100, 8'd7);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); rstN = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
      miscompares++;
      $display("FAIL midreset_clear: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0", busy8, done8, q8, r8, dz8);
    end
    sb8.delete();
    @(negedge clk); rstN = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL midreset_nodone: got %0d done/busy cycles, want 0", ndone);
    end
    issue8(8'd100, 8'd7);
    wait8(lat, nb);
    e = sb8.pop_front();
    vectors++;
    if ({lat, q8, r8, dz8} !== {32'd9, e.q, e.r, e.dz}) begin
      miscompares++;
      $display("FAIL midreset_redo: got lat=%0d q=%0d r=%0d dz=%b, want lat=9 q=%0d r=%0d", lat, q8, r8, dz8, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random64;
    logic [63:0] a, b;
    exp64_t e;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0: b = {$urandom, $urandom} >> $urandom_range(0, 60);
        1: begin a = a >> 1; b = a + 64'd1 + 64'($urandom); end
        2: b = 64'h8000_0000_0000_0000;
        default: b = 64'($urandom_range(1, 1000));
      endcase
      if (i == 2) a = '1;
      if (b == 0) b = 64'd1;
      e.a = a; e.b = b; e.q = a / b; e.r = a % b;
      sb64.push_back(e);
      a64 = a; b64 = b; s64 = 1'b1;
      @(posedge clk); #1;
      s64 = 1'b0;
      lat = 1;
      while (done64 !== 1'b1 && lat < 300) begin
        @(posedge clk); #1;
        lat++;
      end
      e = sb64.pop_front();
      vectors++;
      if ({lat, q64, r64, dz64} !== {32'd65, e.q, e.r, 1'b0}) begin
        miscompares++;
        $display("FAIL rand64_result: %h/%h got lat=%0d q=%h r=%h dz=%b, want lat=65 q=%h r=%h", e.a, e.b, lat, q64, r64, dz64, e.q, e.r);
      end
      vectors++;
      if ({128'(q64) * 128'(e.b) + 128'(r64), r64 < e.b} !== {128'(e.a), 1'b1}) begin
        miscompares++;
        $display("FAIL rand64_invariant: %h/%h got q=%h r=%h, want q*d+r==dividend and r<d", e.a, e.b, q64, r64);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_ignore_start;
    test_reset_mid;
    test_random64;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
